// File: rtl/ctrl_pkg.sv
// Shared constants for the sequencer control unit: default field widths,
// opcode encodings and the FSM state type.
package ctrl_pkg;

  localparam int unsigned OPW_DEF = 4;
  localparam int unsigned RW_DEF  = 2;
  localparam int unsigned AW_DEF  = 8;

  localparam int unsigned OP_NOP       = 0;
  localparam int unsigned OP_ALU_FIRST = 1;
  localparam int unsigned OP_ALU_LAST  = 7;
  localparam int unsigned OP_LOAD      = 8;
  localparam int unsigned OP_STORE     = 9;
  localparam int unsigned OP_JMP       = 10;
  localparam int unsigned OP_JZ        = 11;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

endpackage

// File: rtl/seq_control_unit_if.sv
// Instruction, RAM-handshake and control-strobe bundle between the control
// unit (slave) and its fetch/datapath environment (master).
interface seq_control_unit_if import ctrl_pkg::*; #(
  parameter int unsigned OPW = OPW_DEF,
  parameter int unsigned RW  = RW_DEF,
  parameter int unsigned AW  = AW_DEF
) ();
  localparam int unsigned IW = OPW + 2 * RW + AW;

  logic [IW-1:0]  instr;
  logic           instr_valid;
  logic           instr_ready;
  logic           mem_ack;
  logic           zero_flag;
  logic [OPW-1:0] alu_code;
  logic           reg_read;
  logic           reg_write;
  logic           ram_read;
  logic           ram_write;
  logic [AW-1:0]  ram_adr;
  logic [RW-1:0]  reg1;
  logic [RW-1:0]  reg2;
  logic           pc_inc;
  logic           pc_jump;
  logic           halted;
  logic           illegal;

  modport master (
    output instr, instr_valid, mem_ack, zero_flag,
    input  instr_ready, alu_code, reg_read, reg_write, ram_read, ram_write,
           ram_adr, reg1, reg2, pc_inc, pc_jump, halted, illegal
  );

  modport slave (
    input  instr, instr_valid, mem_ack, zero_flag,
    output instr_ready, alu_code, reg_read, reg_write, ram_read, ram_write,
           ram_adr, reg1, reg2, pc_inc, pc_jump, halted, illegal
  );
endinterface

// File: rtl/instr_decoder.sv
// Splits the latched instruction into its fields and classifies the opcode.
module instr_decoder import ctrl_pkg::*; #(
  parameter int unsigned OPW = OPW_DEF,
  parameter int unsigned RW  = RW_DEF,
  parameter int unsigned AW  = AW_DEF
) (
  input  logic [OPW+2*RW+AW-1:0] ir,
  output logic [OPW-1:0]         opcode,
  output logic [RW-1:0]          reg1,
  output logic [RW-1:0]          reg2,
  output logic [AW-1:0]          adr,
  output logic                   is_alu,
  output logic                   is_load,
  output logic                   is_store,
  output logic                   is_jmp,
  output logic                   is_jz,
  output logic                   is_halt,
  output logic                   is_illegal
);
  localparam int unsigned IW = OPW + 2 * RW + AW;

  logic is_nop;

  assign opcode = ir[IW-1 -: OPW];
  assign reg1   = ir[IW-OPW-1 -: RW];
  assign reg2   = ir[AW+RW-1 -: RW];
  assign adr    = ir[AW-1:0];

  assign is_nop   = (opcode == OPW'(OP_NOP));
  assign is_alu   = (opcode >= OPW'(OP_ALU_FIRST)) && (opcode <= OPW'(OP_ALU_LAST));
  assign is_load  = (opcode == OPW'(OP_LOAD));
  assign is_store = (opcode == OPW'(OP_STORE));
  assign is_jmp   = (opcode == OPW'(OP_JMP));
  assign is_jz    = (opcode == OPW'(OP_JZ));
  assign is_halt  = &opcode;

  // Anything not in the defined opcode map is trapped as illegal.
  assign is_illegal = !(is_nop || is_alu || is_load || is_store ||
                        is_jmp || is_jz || is_halt);

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT FSM driving datapath
// strobes from the state and the latched instruction register.
module seq_control_unit import ctrl_pkg::*; #(
  parameter int unsigned OPW = OPW_DEF,
  parameter int unsigned RW  = RW_DEF,
  parameter int unsigned AW  = AW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  seq_control_unit_if.slave   bus
);
  localparam int unsigned IW = OPW + 2 * RW + AW;

  state_t         state, state_nxt;
  logic [IW-1:0]  ir;

  logic [OPW-1:0] opcode;
  logic [RW-1:0]  f_reg1, f_reg2;
  logic [AW-1:0]  f_adr;
  logic           is_alu, is_load, is_store, is_jmp, is_jz, is_halt, is_illegal;

  logic           instr_ready_c, reg_read_c, reg_write_c, ram_read_c, ram_write_c;
  logic           pc_inc_c, pc_jump_c, halted_c, illegal_c;
  logic [OPW-1:0] alu_code_c;

  instr_decoder #(.OPW(OPW), .RW(RW), .AW(AW)) u_dec (
    .ir         (ir),
    .opcode     (opcode),
    .reg1       (f_reg1),
    .reg2       (f_reg2),
    .adr        (f_adr),
    .is_alu     (is_alu),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_jmp     (is_jmp),
    .is_jz      (is_jz),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // State and instruction register; IR only loads on an accepted fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (instr_ready_c && bus.instr_valid) ir <= bus.instr;
    end
  end

  always_comb begin
    state_nxt     = state;
    instr_ready_c = 1'b0;
    alu_code_c    = '0;
    reg_read_c    = 1'b0;
    reg_write_c   = 1'b0;
    ram_read_c    = 1'b0;
    ram_write_c   = 1'b0;
    pc_inc_c      = 1'b0;
    pc_jump_c     = 1'b0;
    halted_c      = 1'b0;
    illegal_c     = 1'b0;

    unique case (state)
      ST_FETCH: begin
        instr_ready_c = 1'b1;
        if (bus.instr_valid) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        reg_read_c = is_alu || is_store;
        state_nxt  = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt = ST_FETCH;
        if (is_alu) begin
          alu_code_c  = opcode;
          reg_write_c = 1'b1;
          pc_inc_c    = 1'b1;
        end else if (is_load || is_store) begin
          state_nxt = ST_MEM;
        end else if (is_jmp) begin
          pc_jump_c = 1'b1;
        end else if (is_jz) begin
          pc_jump_c = bus.zero_flag;
          pc_inc_c  = !bus.zero_flag;
        end else if (is_halt) begin
          state_nxt = ST_HALT;
        end else begin
          illegal_c = is_illegal;
          pc_inc_c  = 1'b1;
        end
      end
      ST_MEM: begin
        // Request stays up through the cycle in which mem_ack is seen.
        ram_read_c  = is_load;
        ram_write_c = is_store;
        if (bus.mem_ack) begin
          if (is_load) begin
            state_nxt = ST_WB;
          end else begin
            pc_inc_c  = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        reg_write_c = 1'b1;
        pc_inc_c    = 1'b1;
        state_nxt   = ST_FETCH;
      end
      ST_HALT: begin
        halted_c = 1'b1;
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  assign bus.instr_ready = instr_ready_c;
  assign bus.alu_code    = alu_code_c;
  assign bus.reg_read    = reg_read_c;
  assign bus.reg_write   = reg_write_c;
  assign bus.ram_read    = ram_read_c;
  assign bus.ram_write   = ram_write_c;
  assign bus.ram_adr     = f_adr;
  assign bus.reg1        = f_reg1;
  assign bus.reg2        = f_reg2;
  assign bus.pc_inc      = pc_inc_c;
  assign bus.pc_jump     = pc_jump_c;
  assign bus.halted      = halted_c;
  assign bus.illegal     = illegal_c;

endmodule

// File: tb/tb_seq_control_unit.sv
// Scoreboard bench for seq_control_unit: per-cycle stimulus and expected
// outputs are queued per scenario, then replayed and compared cycle by cycle.
module tb_seq_control_unit;

  typedef struct packed {
    logic       rdy;
    logic [3:0] alu;
    logic       rr;
    logic       rw;
    logic       rrd;
    logic       rwr;
    logic [7:0] adr;
    logic [1:0] r1;
    logic [1:0] r2;
    logic       inc;
    logic       jmp;
    logic       hlt;
    logic       ill;
  } obs_t;

  typedef struct packed {
    logic        r;
    logic        v;
    logic [15:0] ins;
    logic        ack;
    logic        zf;
    obs_t        e;
  } step_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  step_t       q[$];
  logic [15:0] ir_m;

  seq_control_unit_if #(.OPW(4), .RW(2), .AW(8)) bus ();
  seq_control_unit_if #(.OPW(5), .RW(3), .AW(10)) pbus ();

  seq_control_unit #(.OPW(4), .RW(2), .AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seq_control_unit #(.OPW(5), .RW(3), .AW(10)) dut_p (
    .clk (clk),
    .rst (rst),
    .bus (pbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one cycle; field outputs follow the model IR.
  function automatic obs_t ex(input logic rdy, input logic [3:0] alu,
                              input logic rr, input logic rw,
                              input logic rrd, input logic rwr,
                              input logic inc, input logic jmp,
                              input logic hlt, input logic ill);
    obs_t o;
    o.rdy = rdy; o.alu = alu; o.rr = rr; o.rw = rw; o.rrd = rrd; o.rwr = rwr;
    o.adr = ir_m[7:0]; o.r1 = ir_m[11:10]; o.r2 = ir_m[9:8];
    o.inc = inc; o.jmp = jmp; o.hlt = hlt; o.ill = ill;
    return o;
  endfunction

  function automatic obs_t idle();
    return ex(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic obs_t busy();
    return ex(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.rdy = bus.instr_ready; o.alu = bus.alu_code;
    o.rr = bus.reg_read; o.rw = bus.reg_write;
    o.rrd = bus.ram_read; o.rwr = bus.ram_write;
    o.adr = bus.ram_adr; o.r1 = bus.reg1; o.r2 = bus.reg2;
    o.inc = bus.pc_inc; o.jmp = bus.pc_jump;
    o.hlt = bus.halted; o.ill = bus.illegal;
    return o;
  endfunction

  task automatic push(input logic r, input logic v, input logic [15:0] ins,
                      input logic ack, input logic zf, input obs_t e);
    step_t s;
    s.r = r; s.v = v; s.ins = ins; s.ack = ack; s.zf = zf; s.e = e;
    q.push_back(s);
  endtask

  task automatic apply(input step_t s);
    @(posedge clk); #1;
    rst = s.r; bus.instr_valid = s.v; bus.instr = s.ins;
    bus.mem_ack = s.ack; bus.zero_flag = s.zf;
    #1;
  endtask

  task automatic test_reset();
    step_t s; obs_t o; int n;
    ir_m = 16'h0000;
    push(0, 0, 16'h0000, 0, 0, idle());
    push(0, 0, 16'h0000, 1, 1, idle());
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s); o = sample(); tests++;
      if (o !== s.e) begin
        fails++; $display("FAIL reset step %0d: got %h want %h", n, o, s.e);
      end
      n++;
    end
  endtask

  task automatic test_alu();
    step_t s; obs_t o; int n;
    push(0, 1, 16'h4D00, 0, 0, idle());
    ir_m = 16'h4D00;
    push(0, 1, 16'hF000, 0, 0, ex(0, 4'd0, 1, 0, 0, 0, 0, 0, 0, 0));
    push(0, 0, 16'h0000, 0, 0, ex(0, 4'd4, 0, 1, 0, 0, 1, 0, 0, 0));
    push(0, 0, 16'h0000, 0, 0, idle());
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s); o = sample(); tests++;
      if (o !== s.e) begin
        fails++; $display("FAIL alu step %0d: got %h want %h", n, o, s.e);
      end
      n++;
    end
  endtask

  task automatic test_load();
    step_t s; obs_t o; int n;
    obs_t rd;
    push(0, 1, 16'h8A3C, 0, 0, idle());
    ir_m = 16'h8A3C;
    rd = ex(0, 4'd0, 0, 0, 1, 0, 0, 0, 0, 0);
    push(0, 0, 16'h0000, 1, 0, busy());
    push(0, 0, 16'h0000, 0, 0, busy());
    push(0, 0, 16'h0000, 0, 0, rd);
    push(0, 0, 16'h0000, 0, 0, rd);
    push(0, 0, 16'h0000, 0, 0, rd);
    push(0, 0, 16'h0000, 1, 0, rd);
    push(0, 0, 16'h0000, 0, 0, ex(0, 4'd0, 0, 1, 0, 0, 1, 0, 0, 0));
    push(0, 0, 16'h0000, 0, 0, idle());
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s); o = sample(); tests++;
      if (o !== s.e) begin
        fails++; $display("FAIL load step %0d: got %h want %h", n, o, s.e);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back_jumps();
    step_t s; obs_t o; int n;
    push(0, 1, 16'hB000, 0, 0, idle());
    ir_m = 16'hB000;
    push(0, 0, 16'h0000, 0, 0, busy());
    push(0, 0, 16'h0000, 0, 1, ex(0, 4'd0, 0, 0, 0, 0, 0, 1, 0, 0));
    push(0, 1, 16'hB000, 0, 0, idle());
    push(0, 0, 16'h0000, 0, 1, busy());
    push(0, 0, 16'h0000, 0, 0, ex(0, 4'd0, 0, 0, 0, 0, 1, 0, 0, 0));
    push(0, 1, 16'hA000, 0, 0, idle());
    ir_m = 16'hA000;
    push(0, 0, 16'h0000, 0, 0, busy());
    push(0, 0, 16'h0000, 0, 0, ex(0, 4'd0, 0, 0, 0, 0, 0, 1, 0, 0));
    push(0, 0, 16'h0000, 0, 0, idle());
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s); o = sample(); tests++;
      if (o !== s.e) begin
        fails++; $display("FAIL jump step %0d: got %h want %h", n, o, s.e);
      end
      n++;
    end
  endtask

  task automatic test_illegal_nop();
    step_t s; obs_t o; int n;
    push(0, 1, 16'hC000, 0, 0, idle());
    ir_m = 16'hC000;
    push(0, 0, 16'h0000, 0, 0, busy());
    push(0, 0, 16'h0000, 0, 0, ex(0, 4'd0, 0, 0, 0, 0, 1, 0, 0, 1));
    push(0, 1, 16'h0000, 0, 0, idle());
    ir_m = 16'h0000;
    push(0, 0, 16'h0000, 0, 0, busy());
    push(0, 0, 16'h0000, 0, 0, ex(0, 4'd0, 0, 0, 0, 0, 1, 0, 0, 0));
    push(0, 0, 16'h0000, 0, 0, idle());
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s); o = sample(); tests++;
      if (o !== s.e) begin
        fails++; $display("FAIL illegal step %0d: got %h want %h", n, o, s.e);
      end
      n++;
    end
  endtask

  task automatic test_store_reset();
    step_t s; obs_t o; int n;
    obs_t wr;
    push(0, 1, 16'h9105, 0, 0, idle());
    ir_m = 16'h9105;
    wr = ex(0, 4'd0, 0, 0, 0, 1, 0, 0, 0, 0);
    push(0, 0, 16'h0000, 0, 0, ex(0, 4'd0, 1, 0, 0, 0, 0, 0, 0, 0));
    push(0, 0, 16'h0000, 0, 0, busy());
    push(0, 0, 16'h0000, 0, 0, wr);
    push(0, 0, 16'h0000, 1, 0, ex(0, 4'd0, 0, 0, 0, 1, 1, 0, 0, 0));
    push(0, 1, 16'h9105, 0, 0, idle());
    push(0, 0, 16'h0000, 0, 0, ex(0, 4'd0, 1, 0, 0, 0, 0, 0, 0, 0));
    push(0, 0, 16'h0000, 0, 0, busy());
    push(1, 0, 16'h0000, 0, 0, wr);
    ir_m = 16'h0000;
    push(0, 0, 16'h0000, 1, 0, idle());
    push(0, 0, 16'h0000, 0, 0, idle());
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s); o = sample(); tests++;
      if (o !== s.e) begin
        fails++; $display("FAIL store step %0d: got %h want %h", n, o, s.e);
      end
      n++;
    end
  endtask

  task automatic test_halt();
    step_t s; obs_t o; int n;
    obs_t h;
    push(0, 1, 16'hF000, 0, 0, idle());
    ir_m = 16'hF000;
    h = ex(0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 0);
    push(0, 0, 16'h0000, 0, 0, busy());
    push(0, 0, 16'h0000, 0, 0, busy());
    push(0, 1, 16'h4D00, 1, 1, h);
    push(0, 1, 16'h4D00, 0, 0, h);
    push(1, 1, 16'h4D00, 0, 0, h);
    ir_m = 16'h0000;
    push(0, 0, 16'h0000, 0, 0, idle());
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s); o = sample(); tests++;
      if (o !== s.e) begin
        fails++; $display("FAIL halt step %0d: got %h want %h", n, o, s.e);
      end
      n++;
    end
  endtask

  task automatic test_param();
    logic [20:0] pi;
    logic [20:0] got;
    logic [20:0] want;
    pi = {5'd3, 3'd5, 3'd2, 10'h2A5};
    @(posedge clk); #1;
    pbus.instr = pi; pbus.instr_valid = 1'b1;
    #1; tests++;
    if (pbus.instr_ready !== 1'b1) begin
      fails++; $display("FAIL param_accept: got ready=%b want 1", pbus.instr_ready);
    end
    @(posedge clk); #1;
    pbus.instr_valid = 1'b0;
    #1; tests++;
    got  = {pbus.reg_read, pbus.reg1, pbus.reg2, pbus.ram_adr, pbus.alu_code[1:0], pbus.instr_ready, pbus.reg_write};
    want = {1'b1, 3'd5, 3'd2, 10'h2A5, 2'd0, 1'b0, 1'b0};
    if (got !== want) begin
      fails++; $display("FAIL param_decode: got %h want %h", got, want);
    end
    @(posedge clk); #2; tests++;
    got  = {pbus.alu_code, pbus.reg_write, pbus.pc_inc, pbus.pc_jump, pbus.reg1, pbus.ram_adr};
    want = {5'd3, 1'b1, 1'b1, 1'b0, 3'd5, 10'h2A5};
    if (got !== want) begin
      fails++; $display("FAIL param_exec: got %h want %h", got, want);
    end
    @(posedge clk); #2; tests++;
    got  = {15'd0, pbus.instr_ready, pbus.alu_code};
    want = {15'd0, 1'b1, 5'd0};
    if (got !== want) begin
      fails++; $display("FAIL param_refetch: got %h want %h", got, want);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    ir_m  = 16'h0000;
    rst   = 1'b1;
    bus.instr = '0;  bus.instr_valid = 1'b0;  bus.mem_ack = 1'b0;  bus.zero_flag = 1'b0;
    pbus.instr = '0; pbus.instr_valid = 1'b0; pbus.mem_ack = 1'b0; pbus.zero_flag = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_alu();
    test_load();
    test_back_to_back_jumps();
    test_illegal_nop();
    test_store_reset();
    test_halt();
    test_param();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
